// File: rtl/alu_bist_pkg.sv
// Shared types, constants and the MISR update function for the ALU BIST driver.
package alu_bist_pkg;

    localparam int MISR_W = 16;
    localparam int IDX_W  = 12;
    localparam logic [MISR_W-1:0] MISR_POLY = 16'h1021;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        SETTLE  = 2'd1,
        CAPTURE = 2'd2,
        DONE    = 2'd3
    } state_e;

    // One MISR step: shift left, fold the polynomial on carry-out, xor in the response byte.
    function automatic logic [MISR_W-1:0] misr_next(input logic [MISR_W-1:0] sig,
                                                    input logic [7:0]        data);
        logic [MISR_W-1:0] nxt;
        nxt = {sig[MISR_W-2:0], 1'b0};
        if (sig[MISR_W-1]) begin
            nxt = nxt ^ MISR_POLY;
        end
        nxt = nxt ^ {8'h00, data};
        return nxt;
    endfunction

endpackage

// File: rtl/alu_bist_misr.sv
// 16-bit multiple-input signature register compacting 8-bit ALU responses.
module alu_bist_misr
    import alu_bist_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              ena,
    input  logic              load,
    input  logic [MISR_W-1:0] seed,
    input  logic              shift_en,
    input  logic [7:0]        data,
    output logic [MISR_W-1:0] sig
);

    logic [MISR_W-1:0] sig_d;
    logic [MISR_W-1:0] sig_q;

    // load wins over shift so a restart never folds a stale response into the seed
    always_comb begin
        sig_d = sig_q;
        if (ena) begin
            if (load) begin
                sig_d = seed;
            end else if (shift_en) begin
                sig_d = misr_next(sig_q, data);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sig_q <= '0;
        end else begin
            sig_q <= sig_d;
        end
    end

    assign sig = sig_q;

endmodule

// File: rtl/alu_bist_driver.sv
// Sweeps every {op, b, a} vector into the ALU, holds each for SETTLE_CYCLES, then
// compacts the response into a MISR and compares the final signature to GOLDEN_SIG.
module alu_bist_driver
    import alu_bist_pkg::*;
#(
    parameter int                OP_COUNT      = 16,
    parameter int                SETTLE_CYCLES = 2,
    parameter logic [MISR_W-1:0] SEED          = 16'hFFFF,
    parameter logic [MISR_W-1:0] GOLDEN_SIG    = 16'h0000
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              ena,
    input  logic              start,
    input  logic [7:0]        resp,
    output logic [3:0]        stim_a,
    output logic [3:0]        stim_b,
    output logic [3:0]        stim_op,
    output logic [IDX_W-1:0]  vec_idx,
    output logic              busy,
    output logic              done,
    output logic              pass,
    output logic [MISR_W-1:0] signature
);

    localparam int CNT_W = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SETTLE_CYCLES - 1);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(OP_COUNT * 256 - 1);

    state_e           state_d,      state_q;
    logic [IDX_W-1:0] vec_idx_d,    vec_idx_q;
    logic [CNT_W-1:0] settle_cnt_d, settle_cnt_q;
    logic             pass_d,       pass_q;

    logic              misr_load;
    logic              misr_shift;
    logic [MISR_W-1:0] misr_sig;

    // start is a one-cycle request sampled only in IDLE/DONE with ena high; there is no
    // acknowledge other than busy rising on the next cycle, and it is ignored otherwise.
    always_comb begin
        state_d      = state_q;
        vec_idx_d    = vec_idx_q;
        settle_cnt_d = settle_cnt_q;
        pass_d       = pass_q;
        misr_load    = 1'b0;
        misr_shift   = 1'b0;

        if (ena) begin
            case (state_q)
                IDLE, DONE: begin
                    if (start) begin
                        state_d      = SETTLE;
                        vec_idx_d    = '0;
                        settle_cnt_d = '0;
                        pass_d       = 1'b0;
                        misr_load    = 1'b1;
                    end
                end
                SETTLE: begin
                    if (settle_cnt_q == CNT_LAST) begin
                        state_d = CAPTURE;
                    end else begin
                        settle_cnt_d = settle_cnt_q + 1'b1;
                    end
                end
                CAPTURE: begin
                    misr_shift = 1'b1;
                    if (vec_idx_q == IDX_LAST) begin
                        state_d = DONE;
                        pass_d  = (misr_next(misr_sig, resp) == GOLDEN_SIG);
                    end else begin
                        state_d      = SETTLE;
                        vec_idx_d    = vec_idx_q + 1'b1;
                        settle_cnt_d = '0;
                    end
                end
                default: begin
                    state_d = IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            vec_idx_q    <= '0;
            settle_cnt_q <= '0;
            pass_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            vec_idx_q    <= vec_idx_d;
            settle_cnt_q <= settle_cnt_d;
            pass_q       <= pass_d;
        end
    end

    alu_bist_misr u_misr (
        .clk      (clk),
        .rst_n    (rst_n),
        .ena      (ena),
        .load     (misr_load),
        .seed     (SEED),
        .shift_en (misr_shift),
        .data     (resp),
        .sig      (misr_sig)
    );

    // a is the inner loop, op the outer loop
    assign stim_a    = vec_idx_q[3:0];
    assign stim_b    = vec_idx_q[7:4];
    assign stim_op   = vec_idx_q[11:8];
    assign vec_idx   = vec_idx_q;
    assign busy      = (state_q == SETTLE) || (state_q == CAPTURE);
    assign done      = (state_q == DONE);
    assign pass      = pass_q;
    assign signature = misr_sig;

endmodule

// File: tb/tb_alu_bist_driver.sv
// Directed bench for alu_bist_driver: a short single-opcode instance for timing and
// corner cases, and a full-sweep instance driven by a behavioural ALU model.
module tb_alu_bist_driver;

    localparam logic [15:0] SEED2    = 16'hFFFF;
    localparam logic [15:0] GOLDEN2  = 16'h0000;
    localparam logic [11:0] FLIP_IDX = 12'h5C3;

    typedef struct {
        logic [11:0] idx;
        logic [3:0]  a;
        logic [3:0]  b;
        logic [3:0]  op;
    } vec_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        ena = 1'b1;
    logic        start1 = 1'b0;
    logic        start2 = 1'b0;
    logic [7:0]  resp1 = 8'h00;
    logic [7:0]  resp2;
    bit          flip_en = 1'b0;

    logic [3:0]  a1, b1, op1, a2, b2, op2;
    logic [11:0] idx1, idx2;
    logic        busy1, done1, pass1, busy2, done2, pass2;
    logic [15:0] sig1, sig2;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    alu_bist_driver #(
        .OP_COUNT(1), .SETTLE_CYCLES(2), .SEED(16'h0000), .GOLDEN_SIG(16'h0000)
    ) dut1 (
        .clk(clk), .rst_n(rst_n), .ena(ena), .start(start1), .resp(resp1),
        .stim_a(a1), .stim_b(b1), .stim_op(op1), .vec_idx(idx1),
        .busy(busy1), .done(done1), .pass(pass1), .signature(sig1)
    );

    alu_bist_driver #(
        .OP_COUNT(16), .SETTLE_CYCLES(2), .SEED(SEED2), .GOLDEN_SIG(GOLDEN2)
    ) dut2 (
        .clk(clk), .rst_n(rst_n), .ena(ena), .start(start2), .resp(resp2),
        .stim_a(a2), .stim_b(b2), .stim_op(op2), .vec_idx(idx2),
        .busy(busy2), .done(done2), .pass(pass2), .signature(sig2)
    );

    function automatic logic [7:0] alu_model(input logic [11:0] v);
        logic [7:0] a, b;
        a = {4'h0, v[3:0]};
        b = {4'h0, v[7:4]};
        case (v[11:8])
            4'd0:    return a + b;
            4'd1:    return a - b;
            4'd2:    return a * b;
            4'd3:    return a & b;
            4'd4:    return a | b;
            4'd5:    return a ^ b;
            4'd6:    return {4'h0, ~v[3:0]};
            4'd7:    return {v[3:0], v[7:4]};
            4'd8:    return a << v[5:4];
            4'd9:    return a >> v[5:4];
            4'd10:   return (a > b) ? 8'h01 : 8'h00;
            default: return {v[11:8], v[3:0] ^ v[7:4]};
        endcase
    endfunction

    function automatic logic [15:0] misr_step(input logic [15:0] s, input logic [7:0] d);
        return {s[14:0], 1'b0} ^ (s[15] ? 16'h1021 : 16'h0000) ^ {8'h00, d};
    endfunction

    always_comb begin
        resp2 = alu_model({op2, b2, a2});
        if (flip_en && ({op2, b2, a2} == FLIP_IDX)) begin
            resp2 = resp2 ^ 8'h04;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic pulse_start1();
        start1 = 1'b1;
        tick();
        start1 = 1'b0;
    endtask

    task automatic wait_done1(output int n);
        n = 0;
        while (!done1 && n < 3000) begin
            tick();
            n++;
        end
    endtask

    task automatic wait_idx1(input logic [11:0] target, output int n);
        n = 0;
        while (idx1 != target && n < 3000) begin
            tick();
            n++;
        end
        chk("wait_idx1_reached", {20'h0, idx1}, {20'h0, target});
    endtask

    task automatic wait_idx2(input logic [11:0] target, output int n);
        n = 0;
        while (idx2 != target && n < 14000) begin
            tick();
            n++;
        end
    endtask

    task automatic wait_done2(output int n);
        n = 0;
        while (!done2 && n < 14000) begin
            tick();
            n++;
        end
    endtask

    initial begin
        vec_t        tbl[5];
        int          n, w, total;
        logic [15:0] e, ref_clean, ref_flip;

        tbl[0] = '{idx: 12'h000, a: 4'h0, b: 4'h0, op: 4'h0};
        tbl[1] = '{idx: 12'h001, a: 4'h1, b: 4'h0, op: 4'h0};
        tbl[2] = '{idx: 12'h01F, a: 4'hF, b: 4'h1, op: 4'h0};
        tbl[3] = '{idx: 12'h2A5, a: 4'h5, b: 4'hA, op: 4'h2};
        tbl[4] = '{idx: 12'hFFF, a: 4'hF, b: 4'hF, op: 4'hF};

        // reset state
        repeat (3) @(posedge clk);
        #1;
        chk("rst_idx", {20'h0, idx1}, 32'h0);
        chk("rst_sig", {16'h0, sig1}, 32'h0);
        chk("rst_flags", {29'h0, busy1, done1, pass1}, 32'h0);
        chk("rst_stim", {20'h0, op1, b1, a1}, 32'h0);
        #2 rst_n = 1'b1;
        tick();

        // start with ena low is ignored
        ena = 1'b0;
        pulse_start1();
        ena = 1'b1;
        tick();
        chk("ena0_start_ignored", {31'h0, busy1}, 32'h0);

        // scenario 1: zero response, exact completion latency
        pulse_start1();
        chk("s1_busy", {31'h0, busy1}, 32'h1);
        chk("s1_idx0", {20'h0, idx1}, 32'h0);
        wait_done1(n);
        chk("s1_latency", n, 768);
        chk("s1_pass", {31'h0, pass1}, 32'h1);
        chk("s1_sig", {16'h0, sig1}, 32'h0);
        chk("s1_last_idx", {20'h0, idx1}, 32'h0FF);
        chk("s1_busy_low", {31'h0, busy1}, 32'h0);

        // scenario 2: 0xA5 during vector 0 only
        resp1 = 8'hA5;
        pulse_start1();
        chk("s2_done_drop", {31'h0, done1}, 32'h0);
        tick();
        tick();
        chk("s2_stim_v0", {20'h0, op1, b1, a1}, 32'h000);
        tick();
        resp1 = 8'h00;
        chk("s2_sig_first", {16'h0, sig1}, 32'h00A5);
        chk("s2_stim_v1", {20'h0, op1, b1, a1}, 32'h001);
        e = 16'h00A5;
        for (int i = 0; i < 255; i++) e = misr_step(e, 8'h00);
        wait_done1(n);
        chk("s2_final_sig", {16'h0, sig1}, {16'h0, e});
        chk("s2_pass", {31'h0, pass1}, {31'h0, (e == 16'h0000)});

        // scenario 4: restart from DONE reloads SEED, then ena dropped for 10 cycles
        pulse_start1();
        chk("s4_restart_sig", {16'h0, sig1}, 32'h0);
        chk("s4_restart_done", {31'h0, done1}, 32'h0);
        wait_idx1(12'd50, w);
        ena = 1'b0;
        for (int i = 0; i < 10; i++) begin
            tick();
            chk("s4_hold", {op1, b1, a1, idx1, sig1[7:0]}, {4'h0, 4'h3, 4'h2, 12'd50, 8'h00});
        end
        ena = 1'b1;
        wait_done1(n);
        chk("s4_latency", w + 10 + n, 778);
        chk("s4_pass", {31'h0, pass1}, 32'h1);

        // scenario 6: start while busy has no effect
        pulse_start1();
        wait_idx1(12'd100, w);
        pulse_start1();
        chk("s6_busy_start_idx", {20'h0, idx1}, 32'd100);
        chk("s6_busy_start_busy", {31'h0, busy1}, 32'h1);
        wait_done1(n);
        chk("s6_latency", w + 1 + n, 768);

        // scenario 5: asynchronous reset mid-sweep
        pulse_start1();
        wait_idx1(12'd100, w);
        #2 rst_n = 1'b0;
        #1;
        chk("s5_rst_idx", {20'h0, idx1}, 32'h0);
        chk("s5_rst_stim", {20'h0, op1, b1, a1}, 32'h0);
        chk("s5_rst_flags", {29'h0, busy1, done1, pass1}, 32'h0);
        chk("s5_rst_sig", {16'h0, sig1}, 32'h0);
        #2 rst_n = 1'b1;
        tick();
        pulse_start1();
        wait_done1(n);
        chk("s5_fresh_latency", n, 768);
        chk("s5_fresh_pass", {31'h0, pass1}, 32'h1);

        // scenario 3: full sweep against the behavioural ALU model
        ref_clean = SEED2;
        ref_flip  = SEED2;
        for (int i = 0; i < 4096; i++) begin
            ref_clean = misr_step(ref_clean, alu_model(12'(i)));
            ref_flip  = misr_step(ref_flip,
                                  alu_model(12'(i)) ^ ((12'(i) == FLIP_IDX) ? 8'h04 : 8'h00));
        end

        start2 = 1'b1;
        tick();
        start2 = 1'b0;
        total = 0;
        for (int k = 0; k < 5; k++) begin
            wait_idx2(tbl[k].idx, w);
            total += w;
            chk("s3_tbl_idx", {20'h0, idx2}, {20'h0, tbl[k].idx});
            chk("s3_tbl_stim", {20'h0, op2, b2, a2}, {20'h0, tbl[k].op, tbl[k].b, tbl[k].a});
        end
        wait_done2(n);
        chk("s3_latency", total + n, 4096 * 3);
        chk("s3_final_idx", {20'h0, idx2}, 32'hFFF);
        chk("s3_sig", {16'h0, sig2}, {16'h0, ref_clean});
        chk("s3_pass", {31'h0, pass2}, {31'h0, (ref_clean == GOLDEN2)});

        flip_en = 1'b1;
        start2 = 1'b1;
        tick();
        start2 = 1'b0;
        chk("s3f_restart_sig", {16'h0, sig2}, {16'h0, SEED2});
        wait_done2(n);
        chk("s3f_latency", n, 4096 * 3);
        chk("s3f_sig", {16'h0, sig2}, {16'h0, ref_flip});
        chk("s3f_pass", {31'h0, pass2}, {31'h0, (ref_flip == GOLDEN2)});

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
